// File: rtl/fetch_queue.sv
// fetch_queue: buffers up to DEPTH fetched instruction words between the
// instruction memory port and decode stage 1, issuing one registered word
// per cycle. Supports stall (block_fetch), branch flush, and a sticky halt.
module fetch_queue #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int OPCODE_WIDTH = 5,
  parameter logic [OPCODE_WIDTH-1:0] NOP_OPCODE  = OPCODE_WIDTH'(1),
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = OPCODE_WIDTH'(31)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         block_fetch,
  input  logic [WIDTH-1:0]             mem_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  output logic [WIDTH-1:0]             outbound_instruction,
  output logic                         outbound_valid,
  output logic                         halted,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [WIDTH-1:0] NOP_WORD = {NOP_OPCODE, {(WIDTH-OPCODE_WIDTH){1'b0}}};

  function automatic logic is_halt(input logic [WIDTH-1:0] word);
    return word[WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             halted_q, halted_d;
  logic             wr_en;
  logic             full, empty, push;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  // Ready depends only on occupancy, halt and flush, never on block_fetch,
  // so a stalled stage 1 still lets the queue absorb in-flight words.
  assign mem_ready = !full && !halted_q && !flush;
  assign push      = mem_valid && mem_ready;

  assign outbound_instruction = out_q;
  assign outbound_valid       = vld_q;
  assign halted               = halted_q;
  assign count                = count_q;

  // Next-state: flush > halted > stall > pop > bypass > idle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = NOP_WORD;
    vld_d    = 1'b0;
    halted_d = halted_q;
    wr_en    = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (halted_q) begin
      // Frozen until reset; remaining queued words are never issued.
    end else if (block_fetch) begin
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        count_d  = count_q + CW'(1);
      end
    end else if (!empty) begin
      out_d    = mem_q[rd_ptr_q];
      vld_d    = 1'b1;
      halted_d = is_halt(mem_q[rd_ptr_q]);
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        count_d  = count_q - CW'(1);
      end
    end else if (push) begin
      // Empty queue: hand the incoming word straight to stage 1.
      out_d    = mem_data;
      vld_d    = 1'b1;
      halted_d = is_halt(mem_data);
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= NOP_WORD;
      vld_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
      halted_q <= halted_d;
    end
  end

  // Queue storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      mem_q[wr_ptr_q] <= mem_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (default parameters: WIDTH=32, DEPTH=4,
// NOP opcode 5'h01 -> NOP word 0x08000000, HALT opcode 5'h1F).
module tb_fetch_queue;

  localparam logic [31:0] NOP  = 32'h0800_0000;
  localparam logic [31:0] HALT = 32'hF800_0123;

  logic        clk;
  logic        reset, flush, block_fetch, mem_valid;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [31:0] outbound_instruction;
  logic        outbound_valid, halted;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;

  fetch_queue dut (
    .clock(clk), .reset(reset), .flush(flush), .block_fetch(block_fetch),
    .mem_data(mem_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .outbound_instruction(outbound_instruction), .outbound_valid(outbound_valid),
    .halted(halted), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; block_fetch = 1'b0; mem_valid = 1'b0; mem_data = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_vec++; if (outbound_instruction !== NOP) begin n_err++; $display("FAIL reset_out: got %h want %h", outbound_instruction, NOP); end
    n_vec++; if (outbound_valid !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", outbound_valid); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", mem_ready); end
  endtask

  task automatic test_bypass();
    logic [31:0] w [2];
    w[0] = 32'h1000_0001; w[1] = 32'h1000_0002;
    mem_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_data = w[i];
      tick();
      n_vec++; if (outbound_instruction !== w[i] || outbound_valid !== 1'b1)
        begin n_err++; $display("FAIL bypass_%0d: got %h/%b want %h/1", i, outbound_instruction, outbound_valid, w[i]); end
      n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL bypass_count_%0d: got %0d want 0", i, count); end
    end
    mem_valid = 1'b0;
    tick();
    n_vec++; if (outbound_instruction !== NOP || outbound_valid !== 1'b0)
      begin n_err++; $display("FAIL bypass_idle: got %h/%b want %h/0", outbound_instruction, outbound_valid, NOP); end
  endtask

  task automatic test_stall();
    block_fetch = 1'b1; mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_data = 32'h1100_0000 + 32'(i);
      tick();
      n_vec++; if (outbound_instruction !== NOP || outbound_valid !== 1'b0)
        begin n_err++; $display("FAIL stall_nop_%0d: got %h/%b want %h/0", i, outbound_instruction, outbound_valid, NOP); end
      n_vec++; if (count !== 3'(i + 1)) begin n_err++; $display("FAIL stall_count_%0d: got %0d want %0d", i, count, i + 1); end
    end
    mem_data = 32'h11FF_FFFF;
    #1;
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready_full: got %b want 0", mem_ready); end
    tick();
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL stall_ignore_full: got %0d want 4", count); end
    block_fetch = 1'b0; mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (outbound_instruction !== 32'h1100_0000 + 32'(i) || outbound_valid !== 1'b1)
        begin n_err++; $display("FAIL stall_drain_%0d: got %h/%b want %h/1", i, outbound_instruction, outbound_valid, 32'h1100_0000 + 32'(i)); end
      n_vec++; if (count !== 3'(3 - i)) begin n_err++; $display("FAIL stall_drain_count_%0d: got %0d want %0d", i, count, 3 - i); end
    end
    tick();
    n_vec++; if (outbound_valid !== 1'b0) begin n_err++; $display("FAIL stall_after: got vld %b want 0", outbound_valid); end
  endtask

  task automatic test_flush();
    block_fetch = 1'b1; mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_data = 32'h1200_0000 + 32'(i);
      tick();
    end
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL flush_fill: got %0d want 4", count); end
    block_fetch = 1'b0; flush = 1'b1; mem_data = 32'hDEAD_BEEF;
    #1;
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", mem_ready); end
    tick();
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
    n_vec++; if (outbound_instruction !== NOP || outbound_valid !== 1'b0)
      begin n_err++; $display("FAIL flush_out: got %h/%b want %h/0", outbound_instruction, outbound_valid, NOP); end
    flush = 1'b0; mem_data = 32'h2000_0005;
    tick();
    n_vec++; if (outbound_instruction !== 32'h2000_0005 || outbound_valid !== 1'b1 || count !== 3'd0)
      begin n_err++; $display("FAIL flush_bypass: got %h/%b/%0d want 20000005/1/0", outbound_instruction, outbound_valid, count); end
    mem_valid = 1'b0;
    tick();
    n_vec++; if (outbound_valid !== 1'b0) begin n_err++; $display("FAIL flush_idle: got vld %b want 0", outbound_valid); end
  endtask

  task automatic test_halt();
    logic [31:0] w [3];
    w[0] = 32'h1300_0001; w[1] = HALT; w[2] = 32'h1300_0003;
    block_fetch = 1'b1; mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_data = w[i];
      tick();
    end
    n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL halt_fill: got %0d want 3", count); end
    block_fetch = 1'b0; mem_valid = 1'b0;
    tick();
    n_vec++; if (outbound_instruction !== w[0] || outbound_valid !== 1'b1 || halted !== 1'b0)
      begin n_err++; $display("FAIL halt_x: got %h/%b/%b want %h/1/0", outbound_instruction, outbound_valid, halted, w[0]); end
    tick();
    n_vec++; if (outbound_instruction !== HALT || outbound_valid !== 1'b1 || halted !== 1'b1)
      begin n_err++; $display("FAIL halt_issue: got %h/%b/%b want %h/1/1", outbound_instruction, outbound_valid, halted, HALT); end
    mem_valid = 1'b1; mem_data = 32'h1300_00FF;
    #1;
    n_vec++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL halt_ready: got %b want 0", mem_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (outbound_instruction !== NOP || outbound_valid !== 1'b0 || halted !== 1'b1 || count !== 3'd1)
        begin n_err++; $display("FAIL halt_frozen_%0d: got %h/%b/%b/%0d want %h/0/1/1", i, outbound_instruction, outbound_valid, halted, count, NOP); end
    end
    mem_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (halted !== 1'b0 || count !== 3'd0)
      begin n_err++; $display("FAIL halt_reset: got halted %b count %0d want 0/0", halted, count); end
  endtask

  task automatic test_back_to_back();
    block_fetch = 1'b1; mem_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_data = 32'h3000_0000 + 32'(i);
      tick();
    end
    block_fetch = 1'b0;
    for (int i = 2; i < 8; i++) begin
      mem_data = 32'h3000_0000 + 32'(i);
      tick();
      n_vec++; if (outbound_instruction !== 32'h3000_0000 + 32'(i - 2) || outbound_valid !== 1'b1 || count !== 3'd2)
        begin n_err++; $display("FAIL b2b_%0d: got %h/%b/%0d want %h/1/2", i, outbound_instruction, outbound_valid, count, 32'h3000_0000 + 32'(i - 2)); end
    end
    mem_valid = 1'b0;
    for (int i = 6; i < 8; i++) begin
      tick();
      n_vec++; if (outbound_instruction !== 32'h3000_0000 + 32'(i) || outbound_valid !== 1'b1)
        begin n_err++; $display("FAIL b2b_drain_%0d: got %h/%b want %h/1", i, outbound_instruction, outbound_valid, 32'h3000_0000 + 32'(i)); end
    end
    tick();
    n_vec++; if (outbound_valid !== 1'b0 || count !== 3'd0)
      begin n_err++; $display("FAIL b2b_empty: got vld %b count %0d want 0/0", outbound_valid, count); end
  endtask

  task automatic test_reset_mid();
    block_fetch = 1'b1; mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_data = 32'h1400_0000 + 32'(i);
      tick();
    end
    n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL rstmid_fill: got %0d want 3", count); end
    reset = 1'b1; block_fetch = 1'b0; mem_data = 32'h1400_0003;
    tick();
    reset = 1'b0; mem_valid = 1'b0;
    n_vec++; if (count !== 3'd0 || outbound_instruction !== NOP || outbound_valid !== 1'b0 || halted !== 1'b0)
      begin n_err++; $display("FAIL rstmid: got %0d/%h/%b/%b want 0/%h/0/0", count, outbound_instruction, outbound_valid, halted, NOP); end
    tick();
    n_vec++; if (outbound_valid !== 1'b0 || count !== 3'd0)
      begin n_err++; $display("FAIL rstmid_after: got vld %b count %0d want 0/0", outbound_valid, count); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_stall();
    test_flush();
    test_halt();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
